// File: rtl/chunk_serial_adder.sv
// Multi-cycle unsigned adder: CHUNK bits per clock with a registered inter-chunk carry.
// Optional signed-overflow output is enabled by defining OVERFLOW_DETECT_EN.
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVERFLOW_DETECT_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One CHUNK-bit add with carry; MSB of the result is the carry out.
    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             c
    );
        chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CHUNK:0]     add_s;
    logic [POS_W-1:0]   base_s;
`ifdef OVERFLOW_DETECT_EN
    logic               ovf_q, ovf_d;
    logic               msb_cin_s;
`endif

    // Shadow operands shift right each RUN cycle, so the active chunk is always the low one.
    always_comb begin
        add_s  = chunk_add(a_sh_q[CHUNK-1:0], b_sh_q[CHUNK-1:0], carry_q);
        base_s = POS_W'(idx_q) * POS_W'(CHUNK);
    end

`ifdef OVERFLOW_DETECT_EN
    // Carry into the operand MSB, recovered from the MSB sum bit of the final chunk.
    always_comb begin
        msb_cin_s = a_sh_q[CHUNK-1] ^ b_sh_q[CHUNK-1] ^ add_s[CHUNK-1];
    end
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef OVERFLOW_DETECT_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = {IDX_W{1'b0}};
                    carry_d = cin;
                    a_sh_d  = a;
                    b_sh_d  = b;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[base_s +: CHUNK] = add_s[CHUNK-1:0];
                carry_d = add_s[CHUNK];
                a_sh_d  = a_sh_q >> CHUNK;
                b_sh_d  = b_sh_q >> CHUNK;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    cout_d  = add_s[CHUNK];
`ifdef OVERFLOW_DETECT_EN
                    ovf_d   = msb_cin_s ^ add_s[CHUNK];
`endif
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            carry_q <= 1'b0;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef OVERFLOW_DETECT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef OVERFLOW_DETECT_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed self-checking bench for chunk_serial_adder (WIDTH=8 with CHUNK=4 and CHUNK=8).
module tb_chunk_serial_adder;

    logic       clk;
    logic       rst;
    logic       start, cin;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
`ifdef OVERFLOW_DETECT_EN
    logic       ovf, ovf8;
`endif

    int n_cmp = 0;
    int n_err = 0;

    chunk_serial_adder #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef OVERFLOW_DETECT_EN
        , .ovf(ovf)
`endif
    );

    chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef OVERFLOW_DETECT_EN
        , .ovf(ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (sum !== 8'h00) begin n_err++; $display("FAIL reset_sum got %h want 00", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_chunk_carry();
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL carry_busy1 got busy=%b done=%b want 1/0", busy, done); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL carry_busy2 got busy=%b done=%b want 1/0", busy, done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL carry_done got done=%b busy=%b want 1/0", done, busy); end
        n_cmp++; if (sum !== 8'h10 || cout !== 1'b0) begin n_err++; $display("FAIL carry_sum got %h/%b want 10/0", sum, cout); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || sum !== 8'h10) begin n_err++; $display("FAIL carry_hold got done=%b sum=%h want 0/10", done, sum); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; a = 8'hFF; b = 8'h00; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done1 got %b want 1", done); end
        n_cmp++; if (sum !== 8'h00 || cout !== 1'b1) begin n_err++; $display("FAIL b2b_sum1 got %h/%b want 00/1", sum, cout); end
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_relaunch got busy=%b done=%b want 1/0", busy, done); end
        repeat (2) @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done2 got %b want 1", done); end
        n_cmp++; if (sum !== 8'h46 || cout !== 1'b0) begin n_err++; $display("FAIL b2b_sum2 got %h/%b want 46/0", sum, cout); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        start = 1'b1; a = 8'h20; b = 8'h05; cin = 1'b0;
        @(negedge clk);
        a = 8'hAA; b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || sum !== 8'h25) begin n_err++; $display("FAIL busy_ign_sum got done=%b sum=%h want 1/25", done, sum); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL busy_ign_idle got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_reset_abort();
        int seen_done;
        start = 1'b1; a = 8'hF0; b = 8'h10; cin = 1'b0;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            n_err++; $display("FAIL abort_outs got busy=%b done=%b sum=%h cout=%b want 0/0/00/0", busy, done, sum, cout);
        end
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done++;
        end
        n_cmp++; if (seen_done != 0) begin n_err++; $display("FAIL abort_nodone got %0d done cycles want 0", seen_done); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || sum !== 8'h00 || cout !== 1'b1) begin
            n_err++; $display("FAIL abort_relaunch got done=%b sum=%h cout=%b want 1/00/1", done, sum, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || sum !== 8'h80 || cout !== 1'b0) begin n_err++; $display("FAIL ovf_pos got done=%b sum=%h cout=%b want 1/80/0", done, sum, cout); end
`ifdef OVERFLOW_DETECT_EN
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pos_flag got %b want 1", ovf); end
`endif
        start = 1'b1; a = 8'h80; b = 8'h80;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || sum !== 8'h00 || cout !== 1'b1) begin n_err++; $display("FAIL ovf_neg got done=%b sum=%h cout=%b want 1/00/1", done, sum, cout); end
`ifdef OVERFLOW_DETECT_EN
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_neg_flag got %b want 1", ovf); end
`endif
        start = 1'b1; a = 8'h05; b = 8'h03;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (sum !== 8'h08 || cout !== 1'b0) begin n_err++; $display("FAIL ovf_none got %h/%b want 08/0", sum, cout); end
`ifdef OVERFLOW_DETECT_EN
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_none_flag got %b want 0", ovf); end
`endif
        @(negedge clk);
    endtask

    task automatic test_single_chunk();
        start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        n_cmp++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin n_err++; $display("FAIL n1_busy got busy=%b done=%b want 1/0", busy8, done8); end
        @(negedge clk);
        n_cmp++; if (done8 !== 1'b1 || busy8 !== 1'b0) begin n_err++; $display("FAIL n1_done got done=%b busy=%b want 1/0", done8, busy8); end
        n_cmp++; if (sum8 !== 8'h80 || cout8 !== 1'b0) begin n_err++; $display("FAIL n1_sum got %h/%b want 80/0", sum8, cout8); end
`ifdef OVERFLOW_DETECT_EN
        n_cmp++; if (ovf8 !== 1'b1) begin n_err++; $display("FAIL n1_ovf got %b want 1", ovf8); end
`endif
        @(negedge clk);
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL n1_pulse got %b want 0", done8); end
    endtask

    initial begin
        test_reset();
        test_chunk_carry();
        test_back_to_back();
        test_start_while_busy();
        test_reset_abort();
        test_overflow();
        test_single_chunk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
